// File: rtl/issue_pkg.sv
// issue_pkg: opcodes, issue classes, resource indices and queue-entry type shared by the issue scheduler.
package issue_pkg;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;

    localparam int NRES = 5;

    typedef enum logic [2:0] {CLS_ALU, CLS_MUL, CLS_DIV, CLS_LSB, CLS_ROB_ONLY} issue_cls_e;

    typedef struct packed {
        logic [31:0] instruction;
        logic        c_instruction;
        logic [16:0] pc;
        logic [16:0] jalr_prediction;
        logic        br_prediction;
    } issue_entry_t;

    // JAL and unrecognised opcodes only need a ROB slot.
    function automatic issue_cls_e decode_class(input logic [6:0] op, input logic f7_b0, input logic f3_b2);
        return (op == OP) ? (!f7_b0 ? CLS_ALU : f3_b2 ? CLS_DIV : CLS_MUL) :
               (op inside {OP_IMM, BRANCH, JALR, LUI, AUIPC}) ? CLS_ALU :
               (op inside {LOAD, STORE}) ? CLS_LSB : CLS_ROB_ONLY;
    endfunction
endpackage

// File: rtl/issue_fifo.sv
// issue_fifo: in-order instruction queue with flush; payload reads as zero while empty.
module issue_fifo
    import issue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  issue_entry_t wdata,
    output issue_entry_t rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] head_q, head_d, tail_q, tail_d;
    logic [AW:0]   count_q, count_d;
    issue_entry_t  mem_q [DEPTH];

    always_comb begin
        head_d  = flush ? '0 : head_q + AW'(pop);
        tail_d  = flush ? '0 : tail_q + AW'(push);
        count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[tail_q] <= wdata;
    end

    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    assign rdata = empty ? '0 : mem_q[head_q];
endmodule

// File: rtl/issue_scheduler.sv
// issue_scheduler: queues fetched instructions and issues the head only when ROB and class credits allow.
// Optional counters stat_issued/stat_stall are built with ISSUE_SCHEDULER_STATS_EN.
module issue_scheduler
    import issue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ROB_SIZE    = 32,
    parameter int ALU_RS_SIZE = 8,
    parameter int MUL_RS_SIZE = 4,
    parameter int DIV_RS_SIZE = 2,
    parameter int LSB_SIZE    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rob_rst,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    input  logic [31:0] fetch_instruction,
    input  logic        fetch_c_instruction,
    input  logic [16:0] fetch_pc,
    input  logic [16:0] fetch_jalr_prediction,
    input  logic        fetch_br_prediction,
    output logic        instruction_in,
    output logic [31:0] instruction,
    output logic        c_instruction,
    output logic [16:0] pc,
    output logic [16:0] jalr_prediction,
    output logic        br_prediction,
    input  logic        rob_release,
    input  logic        alu_release,
    input  logic        mul_release,
    input  logic        div_release,
    input  logic        lsb_release,
    output logic [31:0] stat_issued,
    output logic [31:0] stat_stall
);
    localparam int SIZES [NRES] = '{ROB_SIZE, ALU_RS_SIZE, MUL_RS_SIZE, DIV_RS_SIZE, LSB_SIZE};
    localparam int CW = $clog2(ROB_SIZE + ALU_RS_SIZE + MUL_RS_SIZE + DIV_RS_SIZE + LSB_SIZE + 1);

    issue_entry_t    head, wdata;
    issue_cls_e      cls;
    logic            full, empty, push;
    logic [NRES-1:0] need, ok, rel;
    logic [CW-1:0]   credit_q [NRES];
    logic [CW-1:0]   credit_d [NRES];

    assign wdata = {fetch_instruction, fetch_c_instruction, fetch_pc, fetch_jalr_prediction, fetch_br_prediction};
    assign rel   = {lsb_release, div_release, mul_release, alu_release, rob_release};

    issue_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (rob_rst),
        .push  (push),
        .pop   (instruction_in),
        .wdata (wdata),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        logic [CW:0] sum;
        sum = '0;
        cls = decode_class(head.instruction[6:0], head.instruction[25], head.instruction[14]);
        need = {cls == CLS_LSB, cls == CLS_DIV, cls == CLS_MUL, cls == CLS_ALU, 1'b1};
        for (int i = 0; i < NRES; i++) ok[i] = !need[i] || credit_q[i] != '0;
        fetch_ready = !full;
        push = fetch_valid && !full && !rob_rst;
        instruction_in = !empty && !rob_rst && &ok;
        // Releases that would overflow a counter are clamped at its size.
        for (int i = 0; i < NRES; i++) begin
            sum = {1'b0, credit_q[i]} + (CW+1)'(rel[i]) - (CW+1)'(instruction_in && need[i]);
            credit_d[i] = rob_rst ? CW'(SIZES[i]) : sum > (CW+1)'(SIZES[i]) ? CW'(SIZES[i]) : sum[CW-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NRES; i++) credit_q[i] <= CW'(SIZES[i]);
        end else begin
            for (int i = 0; i < NRES; i++) credit_q[i] <= credit_d[i];
        end
    end

    for (genvar r = 0; r < NRES; r++) begin : g_chk
        assert property (@(posedge clk) disable iff (!rst_n || rob_rst)
            !(rel[r] && credit_q[r] == CW'(SIZES[r])));
    end

    assign instruction     = head.instruction;
    assign c_instruction   = head.c_instruction;
    assign pc              = head.pc;
    assign jalr_prediction = head.jalr_prediction;
    assign br_prediction   = head.br_prediction;

`ifdef ISSUE_SCHEDULER_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d, stat_stall_q, stat_stall_d;

    always_comb begin
        stat_issued_d = stat_issued_q + 32'(instruction_in);
        stat_stall_d  = stat_stall_q + 32'(!empty && !instruction_in && !rob_rst);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            stat_stall_q  <= stat_stall_d;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`else
    assign stat_issued = '0;
    assign stat_stall  = '0;
`endif
endmodule

// File: tb/tb_issue_scheduler.sv
// tb_issue_scheduler: vector table, directed corner sequences and random traffic against a queue/credit model.
module tb_issue_scheduler;
    localparam int SZ [5] = '{32, 8, 4, 2, 8};
    localparam logic [31:0] I_A   = 32'h00500093;
    localparam logic [31:0] I_B   = 32'h00A00113;
    localparam logic [31:0] I_C   = 32'h002081B3;
    localparam logic [31:0] I_DIV = 32'h0220C1B3;
    localparam logic [31:0] I_LW  = 32'h0000A103;
    localparam logic [31:0] I_JAL = 32'h0000006F;

    typedef struct {
        logic        fv;
        logic [31:0] ins;
        logic [16:0] p;
        logic        e_iss;
        logic [31:0] e_ins;
    } vec_t;

    logic        clk = 0, rst_n = 0, rob_rst = 0;
    logic        fetch_valid = 0, fetch_c_instruction = 0, fetch_br_prediction = 0;
    logic [31:0] fetch_instruction = '0;
    logic [16:0] fetch_pc = '0, fetch_jalr_prediction = '0;
    logic [4:0]  relv = '0;
    logic        fetch_ready, instruction_in, c_instruction, br_prediction;
    logic [31:0] instruction, stat_issued, stat_stall;
    logic [16:0] pc, jalr_prediction;

    int          nvec = 0, nmis = 0;
    logic [48:0] mq [$];
    int          mcr [5];
    int          mhead, st_iss, st_stall;
    logic        s_iss, s_rdy;
    logic [31:0] s_ins;

    always #5 clk = ~clk;

    issue_scheduler dut (
        .clk(clk), .rst_n(rst_n), .rob_rst(rob_rst),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_instruction(fetch_instruction), .fetch_c_instruction(fetch_c_instruction),
        .fetch_pc(fetch_pc), .fetch_jalr_prediction(fetch_jalr_prediction),
        .fetch_br_prediction(fetch_br_prediction),
        .instruction_in(instruction_in), .instruction(instruction), .c_instruction(c_instruction),
        .pc(pc), .jalr_prediction(jalr_prediction), .br_prediction(br_prediction),
        .rob_release(relv[0]), .alu_release(relv[1]), .mul_release(relv[2]),
        .div_release(relv[3]), .lsb_release(relv[4]),
        .stat_issued(stat_issued), .stat_stall(stat_stall)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Resource index needed besides the ROB: 0 none, 1 ALU, 2 MUL, 3 DIV, 4 LSB.
    function automatic int mcls(input logic [31:0] i);
        case (i[6:0])
            7'b0110011: return !i[25] ? 1 : (i[14] ? 3 : 2);
            7'b0010011, 7'b1100011, 7'b1100111, 7'b0110111, 7'b0010111: return 1;
            7'b0000011, 7'b0100011: return 4;
            default: return 0;
        endcase
    endfunction

    task automatic do_reset();
        rst_n = 0;
        fetch_valid = 0;
        relv = '0;
        rob_rst = 0;
        @(negedge clk);
        chk("rst instruction_in", instruction_in, 1'b0);
        chk("rst fetch_ready", fetch_ready, 1'b1);
        chk("rst instruction", instruction, 32'd0);
        chk("rst pc", pc, 17'd0);
        chk("rst jalr_prediction", jalr_prediction, 17'd0);
        chk("rst stat_issued", stat_issued, 32'd0);
        chk("rst stat_stall", stat_stall, 32'd0);
        for (int i = 0; i < 5; i++) chk($sformatf("rst credit%0d", i), dut.credit_q[i], SZ[i]);
        @(posedge clk);
        #1 rst_n = 1;
        mq.delete();
        mhead = 0;
        st_iss = 0;
        st_stall = 0;
        for (int i = 0; i < 5; i++) mcr[i] = SZ[i];
    endtask

    task automatic cyc(input logic fv, input logic [31:0] ins, input logic [16:0] p,
                       input logic [4:0] rel, input logic rr);
        logic        exp_iss, rdy, ne;
        logic [48:0] h;
        logic [16:0] ej;
        int          c;
        fetch_valid = fv;
        fetch_instruction = ins;
        fetch_pc = p;
        fetch_c_instruction = p[0];
        fetch_jalr_prediction = ~p;
        fetch_br_prediction = p[1];
        relv = rel;
        rob_rst = rr;
        @(negedge clk);
        ne = mq.size() != 0;
        h = ne ? mq[0] : '0;
        ej = ne ? ~h[16:0] : 17'd0;
        rdy = mq.size() < 8;
        c = mcls(h[48:17]);
        exp_iss = ne && !rr && mcr[0] > 0 && (c == 0 || mcr[c] > 0);
        chk("instruction_in", instruction_in, exp_iss);
        chk("fetch_ready", fetch_ready, rdy);
        chk("instruction", instruction, h[48:17]);
        chk("pc", pc, h[16:0]);
        chk("c_instruction", c_instruction, ne && h[0]);
        chk("jalr_prediction", jalr_prediction, ej);
        chk("br_prediction", br_prediction, ne && h[1]);
        chk("count", dut.u_fifo.count_q, mq.size());
        chk("head_ptr", dut.u_fifo.head_q, mhead);
        for (int i = 0; i < 5; i++) chk($sformatf("credit%0d", i), dut.credit_q[i], mcr[i]);
`ifdef ISSUE_SCHEDULER_STATS_EN
        chk("stat_issued", stat_issued, st_iss);
        chk("stat_stall", stat_stall, st_stall);
`else
        chk("stat_issued", stat_issued, 32'd0);
        chk("stat_stall", stat_stall, 32'd0);
`endif
        s_iss = instruction_in;
        s_rdy = fetch_ready;
        s_ins = instruction;
        if (rr) begin
            mq.delete();
            mhead = 0;
            for (int i = 0; i < 5; i++) mcr[i] = SZ[i];
        end else begin
            if (exp_iss) begin
                void'(mq.pop_front());
                mcr[0]--;
                if (c != 0) mcr[c]--;
                mhead = (mhead + 1) % 8;
                st_iss++;
            end else if (ne) st_stall++;
            for (int i = 0; i < 5; i++) if (rel[i] && mcr[i] < SZ[i]) mcr[i]++;
            if (fv && rdy) mq.push_back({ins, p});
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tv [5];
        logic [31:0] ins;
        logic [4:0]  r;
        tv = '{'{1'b1, I_A, 17'h00100, 1'b0, 32'd0},
               '{1'b1, I_B, 17'h00104, 1'b1, I_A},
               '{1'b1, I_C, 17'h00106, 1'b1, I_B},
               '{1'b0, 32'd0, 17'd0, 1'b1, I_C},
               '{1'b0, 32'd0, 17'd0, 1'b0, 32'd0}};

        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc(tv[i].fv, tv[i].ins, tv[i].p, 5'b0, 1'b0);
            chk($sformatf("tbl%0d issue", i), s_iss, tv[i].e_iss);
            chk($sformatf("tbl%0d instr", i), s_ins, tv[i].e_ins);
        end
        chk("alu credit after 3", dut.credit_q[1], 5);
        chk("rob credit after 3", dut.credit_q[0], 29);

        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, I_DIV, 17'(i * 3), 5'b0, 1'b0);
        cyc(1'b0, 32'd0, 17'd0, 5'b0, 1'b0);
        chk("div third stalls", s_iss, 1'b0);
        cyc(1'b0, 32'd0, 17'd0, 5'b01000, 1'b0);
        chk("div stall on release cycle", s_iss, 1'b0);
        cyc(1'b0, 32'd0, 17'd0, 5'b0, 1'b0);
        chk("div issues after release", s_iss, 1'b1);

        do_reset();
        for (int i = 0; i < 16; i++) cyc(1'b1, I_LW, 17'(i * 4 + 1), 5'b0, 1'b0);
        cyc(1'b1, I_LW, 17'h1FFFF, 5'b0, 1'b0);
        chk("full refuses", s_rdy, 1'b0);
        chk("full count", dut.u_fifo.count_q, 8);
        for (int i = 0; i < 8; i++) cyc(1'b0, 32'd0, 17'd0, 5'b10000, 1'b0);
        cyc(1'b0, 32'd0, 17'd0, 5'b0, 1'b0);
        cyc(1'b0, 32'd0, 17'd0, 5'b0, 1'b0);
        chk("lsb drained count", dut.u_fifo.count_q, 0);
        chk("lsb head wrapped", dut.u_fifo.head_q, 0);

        do_reset();
        for (int i = 0; i < 8; i++) cyc(1'b1, I_A, 17'(i + 8), 5'b0, 1'b0);
        cyc(1'b1, I_B, 17'h0002A, 5'b00010, 1'b0);
        chk("same-cycle issue", s_iss, 1'b1);
        chk("alu credit held at 1", dut.credit_q[1], 1);
        cyc(1'b0, 32'd0, 17'd0, 5'b0, 1'b0);
        chk("alu next issues", s_iss, 1'b1);

        do_reset();
        for (int i = 0; i < 10; i++) cyc(1'b1, I_JAL, 17'(i), 5'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b1, I_DIV, 17'(i + 32), 5'b0, 1'b0);
        chk("pre-flush count", dut.u_fifo.count_q, 5);
        chk("pre-flush rob credit", dut.credit_q[0], 20);
        cyc(1'b1, I_A, 17'h00077, 5'b00011, 1'b1);
        chk("no issue during flush", s_iss, 1'b0);
        chk("flush count", dut.u_fifo.count_q, 0);
        chk("flush rob credit", dut.credit_q[0], 32);
        chk("flush div credit", dut.credit_q[3], 2);
        cyc(1'b0, 32'd0, 17'd0, 5'b0, 1'b0);
        chk("flush fetch dropped", s_iss, 1'b0);

        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, I_DIV, 17'(i), 5'b0, 1'b0);
        for (int i = 0; i < 10; i++) cyc(1'b0, 32'd0, 17'd0, (i == 9) ? 5'b01000 : 5'b0, 1'b0);
        cyc(1'b1, I_A, 17'h00050, 5'b0, 1'b0);
        cyc(1'b0, 32'd0, 17'd0, 5'b0, 1'b0);
`ifdef ISSUE_SCHEDULER_STATS_EN
        chk("stat_stall total", stat_stall, 10);
        chk("stat_issued total", stat_issued, 4);
`else
        chk("stat_stall tied", stat_stall, 0);
        chk("stat_issued tied", stat_issued, 0);
`endif

        do_reset();
        for (int n = 0; n < 600; n++) begin
            ins = $urandom;
            case ($urandom_range(0, 7))
                0: ins[6:0] = 7'b0010011;
                1: begin ins[6:0] = 7'b0110011; ins[25] = 1'b0; end
                2: begin ins[6:0] = 7'b0110011; ins[25] = 1'b1; ins[14] = 1'b0; end
                3: begin ins[6:0] = 7'b0110011; ins[25] = 1'b1; ins[14] = 1'b1; end
                4: ins[6:0] = 7'b0000011;
                5: ins[6:0] = 7'b0100011;
                6: ins[6:0] = 7'b1101111;
                default: ins[6:0] = 7'b1111111;
            endcase
            for (int i = 0; i < 5; i++) r[i] = ($urandom_range(0, 2) == 0) && mcr[i] < SZ[i];
            cyc($urandom_range(0, 3) != 0, ins, 17'($urandom), r, $urandom_range(0, 49) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
- Buffers fetched instructions in a small in-order queue and issues the head to the decoder only when every downstream structure it needs has a free slot.
- Free slots are tracked with per-resource credit counters (ROB, ALU RS, MUL RS, DIV RS, LSB). Counters decrement on issue and increment on release pulses from those units.
- Sits between the fetcher and the decoder, and replaces ad-hoc full-flag gating.

Parameters:
- DEPTH, 8, queue entries (power of 2, ≥2)
- ROB_SIZE, 32, ROB entries
- ALU_RS_SIZE, 8, ALU reservation-station entries
- MUL_RS_SIZE, 4, MUL reservation-station entries
- DIV_RS_SIZE, 2, DIV reservation-station entries
- LSB_SIZE, 8, load/store buffer entries

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- rob_rst  in  1  synchronous flush (mispredict), active-high
- fetch_valid  in  1  fetcher offers an instruction
- fetch_ready  out  1  queue accepts (count < DEPTH)
- fetch_instruction  in  32  raw (expanded) instruction
- fetch_c_instruction  in  1  original was compressed
- fetch_pc  in  17  instruction address
- fetch_jalr_prediction  in  17  predicted jalr target
- fetch_br_prediction  in  1  predicted branch taken
- instruction_in  out  1  issue strobe to decoder
- instruction  out  32  head instruction
- c_instruction  out  1  head compressed flag
- pc  out  17  head pc
- jalr_prediction  out  17  head jalr prediction
- br_prediction  out  1  head branch prediction
- rob_release, alu_release, mul_release, div_release, lsb_release  in  1 each  one slot freed this cycle
- stat_issued  out  32  issued-instruction count (optional feature)
- stat_stall  out  32  stall-cycle count (optional feature)

Behaviour:
- Reset (rst_n=0, async):
  - count, head and tail pointers are 0.
  - Every credit counter is at its *_SIZE value.
  - instruction_in=0 and fetch_ready=1; the stat counters are 0.
  - All payload outputs are 0.
- Enqueue:
  - Occurs when fetch_valid && fetch_ready && !rob_rst.
  - Writes the entry at the tail, then tail+1 mod DEPTH.
  - fetch_ready depends only on registered count. A full queue refuses even when a dequeue happens in the same cycle.
- Class decode of head opcode (op=instruction[6:0]):
  - ALU: op is 0010011, 1100011, 1100111, 0110111 or 0010111; or op=0110011 with instruction[25]=0.
  - MUL: op=0110011, instruction[25]=1, instruction[14]=0.
  - DIV: op=0110011, instruction[25]=1, instruction[14]=1.
  - LSB: op is 0000011 or 0100011.
  - ROB-only: op=1101111 (jal).
  - Unknown opcode: ROB-only.
- Every instruction needs 1 ROB credit, plus 1 credit of its class (none for ROB-only).
- Issue:
  - Combinational: instruction_in = (count≠0) && !rob_rst && all required credits > 0.
  - Payload outputs are the head entry, combinationally from storage, valid whenever count≠0.
  - On issue: head+1 mod DEPTH.
- Latency: no bypass. An entry enqueued at edge N issues at the earliest in the cycle after edge N, i.e. it is sampled by the decoder at edge N+1.
- Credit update per cycle: credit_next = credit − issued_this_class + release.
  - Issue and release in the same cycle leave the credit unchanged.
  - A release while a credit is at its SIZE is illegal; the simulation assertion fires and the credit saturates at SIZE.
- Count update: +1 on enqueue, −1 on issue, unchanged on both.
- Flush (rob_rst=1, synchronous, single cycle or held):
  - count, head and tail are set to 0, and all credits are set to SIZE.
  - Release pulses are ignored that cycle.
  - No issue or enqueue occurs.
  - stat counters keep their values.
- Order is strictly in-order. A blocked head blocks all younger entries.
- The wrap-around of head/tail at DEPTH−1 → 0 is seamless.

Optional Feature:
- Macro: ISSUE_SCHEDULER_STATS_EN.
- Defined:
  - stat_issued increments on each issue.
  - stat_stall increments in each cycle with count≠0 && !instruction_in && !rob_rst.
  - Both counters wrap modulo 2^32 and are cleared only by rst_n.
- Undefined: both ports are tied to 0 and no counter registers are synthesized.

Decomposition:
- Shared package issue_pkg holds:
  - opcode constants (OP_IMM, OP, BRANCH, JALR, JAL, LUI, AUIPC, LOAD, STORE);
  - the issue-class enum (CLS_ALU, CLS_MUL, CLS_DIV, CLS_LSB, CLS_ROB_ONLY);
  - the queue-entry struct (instruction, c_instruction, pc, jalr_prediction, br_prediction).
- One sub-module, issue_fifo, provides parameterised storage, pointers, count, flush, and full/empty.
- The credit logic and class decode stay in the top module.

Test Plan:
- Reset, then three ALU instructions (0x00500093, 0x00A00113, 0x002081B3) at back-to-back fetch_valid:
  - issues on three consecutive cycles, one cycle after each enqueue;
  - ALU credit 8→5 and ROB credit 32→29.
- DIV_RS_SIZE=2, three div ops (0x0220C1B3), no div_release:
  - two issue, the third stalls with instruction_in=0;
  - a div_release pulse lets it issue the next cycle.
- Fill the queue with 8 LSB ops while lsb credit is 0:
  - fetch_ready=0 with 8 entries held;
  - 8 lsb_release pulses drain the queue in order, and the pointers wrap to 0.
- Issue and alu_release in the same cycle at ALU credit 1: credit stays 1, and the next ALU op issues.
- Queue holding 5 entries, ROB credit 20, rob_rst high for one cycle:
  - count=0 and all credits at SIZE on the next cycle;
  - fetch_valid during the flush is dropped, and no issue occurs.
- With ISSUE_SCHEDULER_STATS_EN, a 10-cycle stall then 4 issues: stat_stall=10 and stat_issued=4. Without the macro, both read 0.
